piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out serializer and the successor to the fixed 8-bit PISO register.
- Adds configurable width, selectable bit order, a valid/ready load handshake, a per-bit shift enable (baud/bit tick), frame tracking and completion flags.
- Sits between a parallel data source (e.g. a FIFO or controller) and a serial line driver (UART-style TX, SPI MOSI, LED chain).

Parameters:
WIDTH, 8, number of data bits per frame (2..32)
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first
IDLE_LEVEL, 1, value driven on serial_out when no frame is active

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset; all state is cleared while low
load_valid  in  1  source presents a word on parallel_in
load_ready  out  1  block can accept a word this cycle
parallel_in  in  WIDTH  data word, sampled only on a handshake (load_valid && load_ready)
shift_en  in  1  bit tick; advances the frame by one bit when in SHIFT
serial_out  out  1  current serial bit (registered)
serial_valid  out  1  serial_out carries a frame bit
busy  out  1  high while a frame is in progress (state != IDLE)
done  out  1  single-cycle pulse after the last bit is consumed

Behaviour:
- Reset (reset low, asynchronous) sets:
  - state = IDLE, shift register = 0, bit counter = 0
  - serial_out = IDLE_LEVEL, serial_valid = 0, busy = 0, done = 0
  - load_ready = 1 once reset is released.
- FSM states are IDLE and SHIFT, plus PARITY when PARITY_EN is defined.
- IDLE:
  - load_ready = 1.
  - On a handshake, capture parallel_in into the shift register, clear the counter and go to SHIFT.
  - The first data bit appears on serial_out and serial_valid rises on the next clock edge (1-cycle latency).
  - shift_en is ignored.
- SHIFT:
  - serial_out = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - Each cycle with shift_en = 1 shifts the register toward the output end, zero-filling, and increments the counter.
  - With shift_en = 0, serial_out, serial_valid and the counter hold; there is no timeout.
  - The last bit is counter == WIDTH-1 with shift_en = 1. On that cycle:
    - done = 1 on the next cycle.
    - Without PARITY_EN the state returns to IDLE.
    - load_ready = 1 during the last-bit cycle only. This allows back-to-back frames: a handshake in that cycle reloads the register and stays in SHIFT with no idle gap, and done still pulses.
- In SHIFT outside the last-bit cycle, load_ready = 0; load_valid is ignored and parallel_in is not sampled.
- The counter is $clog2(WIDTH) bits wide and must never wrap mid-frame.
- On return to IDLE with no reload: serial_out = IDLE_LEVEL, serial_valid = 0, busy = 0.
- Reset asserted mid-frame aborts immediately. No done pulse is produced, and the partial frame is discarded.
- Each frame emits exactly WIDTH bits, one per shift_en, regardless of how shift_en is spaced.

Optional Feature:
- Macro: PISO_SERIALIZER_PARITY_EN.
- When defined:
  - After the last data bit, the FSM enters PARITY.
  - serial_out = even parity (XOR) of the captured word, serial_valid = 1.
  - The next shift_en ends the frame: done pulses and back-to-back reload is allowed on that cycle, as above.
  - The frame is WIDTH+1 bits.
- When undefined: the PARITY state, the parity register and all related logic are absent; the frame is WIDTH bits.

Decomposition:
- Shared package piso_pkg holds:
  - state enum typedef (IDLE, SHIFT, PARITY)
  - localparam function for counter width
  - default IDLE_LEVEL constant.
- One natural sub-module: piso_bit_counter. This is a parametrised up-counter with clear, enable and terminal-count output, reused by future SIPO blocks.

Test Plan:
- Reset/idle: release reset, hold load_valid = 0 -> serial_out = 1, serial_valid = 0, busy = 0, load_ready = 1 for 20 cycles.
- MSB-first frame: WIDTH = 8, load 0xA5, shift_en every cycle -> serial_out = 1,0,1,0,0,1,0,1; done pulses once, 1 cycle after the 8th bit; busy for exactly 8 cycles plus load.
- LSB-first with sparse ticks: MSB_FIRST = 0, load 0x3C, shift_en every 4th cycle -> bits 0,0,1,1,1,1,0,0, each held 4 cycles.
- Back-to-back: load 0xFF, then 0x00 presented with load_valid held -> second handshake on the last-bit cycle; 16 contiguous valid bits, two done pulses, serial_valid never drops between frames.
- Reset mid-frame: load 0x81, pull reset low after 3 bits -> outputs return to reset values immediately; no done pulse.
- Parity build: define PISO_SERIALIZER_PARITY_EN, load 0x07 -> 8 data bits followed by a parity bit of 1; done after the 9th shift_en.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer family and the SIPO blocks that will follow it.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b1;

  // Bit-index counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Saturating up-counter with synchronous clear (priority over enable) and a terminal-count flag.
module piso_bit_counter #(
  parameter int CW  = 3,
  parameter int MAX = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(MAX));

  // Holds at MAX rather than wrapping; the owner clears it at frame boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer; optional trailing even-parity bit under PISO_SERIALIZER_PARITY_EN.
// First bit one cycle after load; load_ready is low mid-frame and reopens on the final tick for gapless reloads.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, shifted;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic             frame_end;
  logic             serial_nxt;

  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  assign busy    = (state != IDLE);

  piso_bit_counter #(
    .CW  (CW),
    .MAX (WIDTH - 1)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

`ifdef PISO_SERIALIZER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else if (load_valid && load_ready) begin
      par_q <= ^parallel_in;
    end
  end
`endif

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    load_ready = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shreg_nxt = parallel_in;
          cnt_clr   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_tc) begin
`ifdef PISO_SERIALIZER_PARITY_EN
            state_nxt = PARITY;
            shreg_nxt = '0;
            cnt_clr   = 1'b1;
`else
            frame_end = 1'b1;
`endif
          end else begin
            shreg_nxt = shifted;
            cnt_en    = 1'b1;
          end
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        if (shift_en) frame_end = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase

    // Final tick of a frame: accept the next word here so the line never idles between frames.
    if (frame_end) begin
      load_ready = 1'b1;
      cnt_clr    = 1'b1;
      if (load_valid) begin
        shreg_nxt = parallel_in;
        state_nxt = SHIFT;
      end else begin
        shreg_nxt = '0;
        state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    serial_nxt = IDLE_LEVEL;
    if (state_nxt == SHIFT) begin
      serial_nxt = MSB_FIRST ? shreg_nxt[WIDTH-1] : shreg_nxt[0];
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    if (state_nxt == PARITY) begin
      serial_nxt = par_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      shreg        <= '0;
      serial_out   <= IDLE_LEVEL;
      serial_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      serial_out   <= serial_nxt;
      serial_valid <= (state_nxt != IDLE);
      done         <= frame_end;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances checked against bit-queue scoreboards.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         load_valid, load_ready, shift_en, serial_out, serial_valid, busy, done;
  logic [W-1:0] parallel_in;
  logic         load_valid_l, load_ready_l, shift_en_l, serial_out_l, serial_valid_l, busy_l, done_l;
  logic [W-1:0] parallel_in_l;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .parallel_in(parallel_in), .shift_en(shift_en), .serial_out(serial_out),
    .serial_valid(serial_valid), .busy(busy), .done(done)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid_l), .load_ready(load_ready_l),
    .parallel_in(parallel_in_l), .shift_en(shift_en_l), .serial_out(serial_out_l),
    .serial_valid(serial_valid_l), .busy(busy_l), .done(done_l)
  );

  int   total = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_pop = 0;
  int   done_cnt = 0;
  int   busy_cyc = 0;
  int   done_cnt_l = 0;
  int   valid_cyc_l = 0;
  logic q[$];
  logic ql[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_msb(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
`ifdef PISO_SERIALIZER_PARITY_EN
    q.push_back(^d);
`endif
  endfunction

  function automatic void push_lsb(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) ql.push_back(d[i]);
`ifdef PISO_SERIALIZER_PARITY_EN
    ql.push_back(^d);
`endif
  endfunction

  task automatic wait_done(input string tag, input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    check(tag, done_cnt >= target, 1'b1);
  endtask

  // Main-instance scoreboard: every valid cycle must show the head bit; a tick consumes it.
  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      check("done_latency", cyc - last_pop, 1);
    end
    if (busy) busy_cyc++;
    if (serial_valid) begin
      check("sb_has_bit", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        check("serial_bit", serial_out, q[0]);
        if (shift_en) begin
          void'(q.pop_front());
          last_pop = cyc;
        end
      end
    end else begin
      check("idle_level", serial_out, 1'b1);
    end
  end

  always @(negedge clk) begin
    if (done_l) done_cnt_l++;
    if (serial_valid_l) begin
      valid_cyc_l++;
      check("sb_l_has_bit", ql.size() != 0, 1'b1);
      if (ql.size() != 0) begin
        check("serial_bit_l", serial_out_l, ql[0]);
        if (shift_en_l) void'(ql.pop_front());
      end
    end
  end

  initial begin
    int d0;
    int run;
    bit hs;
    load_valid = 1'b0; parallel_in = '0; shift_en = 1'b0;
    load_valid_l = 1'b0; parallel_in_l = '0; shift_en_l = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_serial_out", serial_out, 1'b1);
      check("rst_serial_valid", serial_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_load_ready", load_ready, 1'b1);
    end

    // MSB-first 0xA5, tick every cycle
    @(posedge clk); #1;
    busy_cyc = 0; d0 = done_cnt;
    push_msb(8'hA5);
    parallel_in = 8'hA5; load_valid = 1'b1; shift_en = 1'b1;
    @(posedge clk); #1 load_valid = 1'b0;
    wait_done("msb_done_seen", d0 + 1);
    #1 shift_en = 1'b0;
    repeat (3) @(posedge clk);
    check("msb_done_once", done_cnt, d0 + 1);
    check("msb_busy_cycles", busy_cyc, FRAME);
    check("msb_sb_empty", q.size(), 0);

    // LSB-first 0x3C, tick every 4th cycle
    @(posedge clk); #1;
    d0 = done_cnt_l; valid_cyc_l = 0;
    push_lsb(8'h3C);
    parallel_in_l = 8'h3C; load_valid_l = 1'b1;
    @(posedge clk); #1 load_valid_l = 1'b0;
    for (int b = 0; b < FRAME; b++) begin
      repeat (3) @(posedge clk);
      #1 shift_en_l = 1'b1;
      @(posedge clk);
      #1 shift_en_l = 1'b0;
    end
    repeat (3) @(posedge clk);
    check("lsb_done_once", done_cnt_l, d0 + 1);
    check("lsb_valid_cycles", valid_cyc_l, 4 * FRAME);
    check("lsb_sb_empty", ql.size(), 0);

    // Back-to-back 0xFF then 0x00 with load_valid held
    @(posedge clk); #1;
    d0 = done_cnt; run = 0; hs = 1'b0;
    push_msb(8'hFF);
    push_msb(8'h00);
    parallel_in = 8'hFF; load_valid = 1'b1; shift_en = 1'b1;
    @(posedge clk); #1 parallel_in = 8'h00;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!serial_valid) break;
      run++;
      if (load_ready && load_valid) hs = 1'b1;
      @(posedge clk); #1;
      if (hs) load_valid = 1'b0;
    end
    @(posedge clk); #1 shift_en = 1'b0;
    repeat (3) @(posedge clk);
    check("b2b_handshake", hs, 1'b1);
    check("b2b_contiguous_bits", run, 2 * FRAME);
    check("b2b_done_pulses", done_cnt, d0 + 2);
    check("b2b_sb_empty", q.size(), 0);

    // Reset mid-frame after 3 bits
    @(posedge clk); #1;
    d0 = done_cnt;
    push_msb(8'h81);
    parallel_in = 8'h81; load_valid = 1'b1; shift_en = 1'b1;
    @(posedge clk); #1 load_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_serial_out", serial_out, 1'b1);
    check("abort_serial_valid", serial_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_popped_3", q.size(), FRAME - 3);
    q.delete();
    shift_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    check("abort_no_done", done_cnt, d0);
    check("abort_ready", load_ready, 1'b1);

    // 0x07: parity bit of 1 follows the data when parity is built in
    @(posedge clk); #1;
    busy_cyc = 0; d0 = done_cnt;
    push_msb(8'h07);
    parallel_in = 8'h07; load_valid = 1'b1; shift_en = 1'b1;
    @(posedge clk); #1 load_valid = 1'b0;
    wait_done("p07_done_seen", d0 + 1);
    #1 shift_en = 1'b0;
    repeat (3) @(posedge clk);
    check("p07_done_once", done_cnt, d0 + 1);
    check("p07_busy_cycles", busy_cyc, FRAME);
    check("p07_sb_empty", q.size(), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
